// File: rtl/wm_sense_timer_if.sv
// wm_sense_timer_if: panel/sensor inputs, controller feedback and conditioned status outputs
interface wm_sense_timer_if #(parameter int LEVEL_W = 8);
  logic door_close_raw;
  logic start_raw;
  logic detergent_sensed;
  logic [LEVEL_W-1:0] level;
  logic motor_on;
  logic drain_value_on;
  logic door_lock;
  logic door_close;
  logic start;
  logic filled;
  logic drained;
  logic detergent_added;
  logic cycle_timeout;
  logic spin_timeout;
  modport master (
    output door_close_raw, start_raw, detergent_sensed, level, motor_on, drain_value_on, door_lock,
    input  door_close, start, filled, drained, detergent_added, cycle_timeout, spin_timeout
  );
  modport slave (
    input  door_close_raw, start_raw, detergent_sensed, level, motor_on, drain_value_on, door_lock,
    output door_close, start, filled, drained, detergent_added, cycle_timeout, spin_timeout
  );
endinterface

// File: rtl/wm_sense_timer.sv
// wm_sense_timer: input conditioning and phase timers feeding the washing-machine controller
module wm_sense_phase_timer #(
  parameter int TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, EXPIRED = 2'b10;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == IDLE) begin
      state <= RUN;
      cnt <= '0;
    end else if (state == RUN && tick) begin
      cnt <= cnt + 1'b1;
      state <= (cnt == LAST) ? EXPIRED : RUN;
    end
  // EXPIRED owns bit 1 so the timeout comes straight off a flop
  assign expired = state[1];
endmodule

module wm_sense_timer #(
  parameter int TICK_DIV    = 100,
  parameter int CYCLE_TICKS = 20,
  parameter int SPIN_TICKS  = 10,
  parameter int DEBOUNCE    = 4,
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int EMPTY_LEVEL = 10
) (
  input logic clk,
  input logic reset,
  wm_sense_timer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  logic [1:0] door_sy, start_sy;
  logic [2:0] det_sy;
  logic [1:0] deb_in, deb_out;
  logic [DW-1:0] deb_cnt [2];
  logic [PW-1:0] pre;
  logic tick, det_rise, spin_phase;
  logic filled_q, drained_q, det_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      door_sy <= '0;
      start_sy <= '0;
      det_sy <= '0;
    end else begin
      door_sy <= {door_sy[0], bus.door_close_raw};
      start_sy <= {start_sy[0], bus.start_raw};
      det_sy <= {det_sy[1:0], bus.detergent_sensed};
    end
  assign deb_in = {start_sy[1], door_sy[1]};
  // a channel toggles only after DEBOUNCE consecutive samples disagree with it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      deb_out <= '0;
      for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
    end else
      for (int k = 0; k < 2; k++)
        if (deb_in[k] == deb_out[k]) deb_cnt[k] <= '0;
        else if (deb_cnt[k] == DB_MAX) begin
          deb_cnt[k] <= '0;
          deb_out[k] <= ~deb_out[k];
        end else deb_cnt[k] <= deb_cnt[k] + 1'b1;
  assign tick = pre == PRE_MAX;
  always_ff @(posedge clk or posedge reset)
    if (reset) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  assign det_rise = det_sy[1] & ~det_sy[2];
  // clearing on door_lock=0 overrides a coincident set
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      filled_q <= 1'b0;
      drained_q <= 1'b0;
      det_q <= 1'b0;
    end else begin
      filled_q <= bus.level >= LEVEL_W'(FULL_LEVEL);
      drained_q <= bus.level <= LEVEL_W'(EMPTY_LEVEL);
      det_q <= bus.door_lock & (det_q | det_rise);
    end
  assign spin_phase = bus.drain_value_on & drained_q & bus.door_lock;
  wm_sense_phase_timer #(.TICKS(CYCLE_TICKS)) u_cycle (
    .clk(clk), .reset(reset), .en(bus.motor_on), .tick(tick), .expired(bus.cycle_timeout)
  );
  wm_sense_phase_timer #(.TICKS(SPIN_TICKS)) u_spin (
    .clk(clk), .reset(reset), .en(spin_phase), .tick(tick), .expired(bus.spin_timeout)
  );
  assign bus.door_close = deb_out[0];
  assign bus.start = deb_out[1];
  assign bus.filled = filled_q;
  assign bus.drained = drained_q;
  assign bus.detergent_added = det_q;
endmodule

// File: doc/wm_sense_timer.md
Name: wm_sense_timer

Overview:
- Input-conditioning and timing stage placed directly upstream of the washing-machine controller FSM.
- Converts raw panel switches, the analog-derived water-level word and the detergent sensor into clean, registered status inputs for the controller: door_close, start, filled, drained, detergent_added.
- Generates cycle_timeout and spin_timeout by timing the controller's own motor_on / drain_value_on / door_lock outputs, so the controller is free of counters.

Parameters:
- TICK_DIV, 100, clk cycles per timer tick (prescaler), ≥2
- CYCLE_TICKS, 20, ticks of motor_on before cycle_timeout, ≥1
- SPIN_TICKS, 10, ticks of spin phase before spin_timeout, ≥1
- DEBOUNCE, 4, consecutive stable synchronized samples required to change door_close/start, ≥2
- LEVEL_W, 8, width of water level input
- FULL_LEVEL, 200, level at/above which filled=1
- EMPTY_LEVEL, 10, level at/below which drained=1; must be < FULL_LEVEL

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- door_close_raw  in  1  raw door switch, asynchronous, bouncy
- start_raw  in  1  raw start button, asynchronous, bouncy
- level  in  LEVEL_W  water level sample, synchronous to clk
- detergent_sensed  in  1  detergent dispenser sensor, asynchronous
- motor_on  in  1  from controller
- drain_value_on  in  1  from controller
- door_lock  in  1  from controller
- door_close  out  1  debounced door switch
- start  out  1  debounced start
- filled  out  1  level ≥ FULL_LEVEL, registered
- drained  out  1  level ≤ EMPTY_LEVEL, registered
- detergent_added  out  1  sticky detergent flag
- cycle_timeout  out  1  wash/rinse agitation time elapsed
- spin_timeout  out  1  spin time elapsed

Behaviour:
- Reset: every output 0. All synchronizers, debounce counters, prescaler and timers are cleared. Asserting reset mid-operation aborts any timing in progress; no state survives.
- Synchronizers: door_close_raw, start_raw and detergent_sensed each pass through a 2-flop synchronizer before any use.
- Debounce (door_close, start):
  - Each channel has its own counter, cleared whenever the synced sample equals the current output.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE-1 with the sample still differing, the output toggles on the next edge and the counter clears.
  - Net latency from a clean raw edge to the output: 2 + DEBOUNCE cycles.
  - A glitch shorter than DEBOUNCE samples never changes the output.
- Level compare:
  - filled <= (level ≥ FULL_LEVEL); drained <= (level ≤ EMPTY_LEVEL). One cycle latency, unsigned compare.
  - Both are never 1 simultaneously, because EMPTY_LEVEL < FULL_LEVEL.
- detergent_added:
  - Set on a rising edge of synced detergent_sensed while door_lock=1.
  - Held until door_lock=0, then cleared on the next edge.
  - A rising edge while door_lock=0 is ignored.
  - If a set and a clear condition occur in the same cycle, clear wins.
- Prescaler: free-running counter 0..TICK_DIV-1; tick=1 for one cycle when the counter equals TICK_DIV-1, then it wraps to 0. The prescaler is never cleared except by reset.
- Cycle timer:
  - States: IDLE, RUN, EXPIRED.
  - IDLE→RUN when motor_on=1 (count=0).
  - In RUN, count increments on each tick. On the tick that makes count = CYCLE_TICKS, go to EXPIRED.
  - cycle_timeout = 1 only in EXPIRED (registered).
  - Any state →IDLE, count cleared, whenever motor_on=0; motor_on=0 takes priority over a simultaneous tick.
  - Consequence: cycle_timeout deasserts one cycle after the controller drops motor_on, so a second (rinse) cycle restarts the full count.
- Spin timer:
  - Same three-state structure, enabled by spin_phase = drain_value_on & drained & door_lock.
  - Counts SPIN_TICKS ticks. spin_timeout = 1 only in its EXPIRED state.
  - Returns to IDLE and clears whenever spin_phase=0.
- Elapsed time: measured from enable to timeout, between (N-1)·TICK_DIV+1 and N·TICK_DIV+1 cycles, due to tick phase (N = CYCLE_TICKS or SPIN_TICKS).
- Count widths: counters are sized with $clog2 of the parameter+1. No wrap is permitted in RUN.

Test Plan:
- Reset check: assert reset during RUN of the cycle timer (count=7) → next cycle all outputs 0. After release with motor_on=1 held, cycle_timeout rises only after the full CYCLE_TICKS again.
- Debounce (DEBOUNCE=4):
  - door_close_raw toggling 0/1 every 2 cycles for 20 cycles → door_close stays 0.
  - Clean 0→1 → door_close=1 exactly 6 cycles later.
- Level thresholds: level=199 → filled=0; level=200 → filled=1 next cycle; level=10 → drained=1; level=11 → drained=0.
- Cycle timer (TICK_DIV=4, CYCLE_TICKS=3):
  - motor_on held high → cycle_timeout=1 within 9–13 cycles.
  - Drop motor_on → cycle_timeout=0 next cycle.
  - Re-raise motor_on → full count again.
- Spin timer: level=5, door_lock=1, drain_value_on=1 → spin_timeout after SPIN_TICKS ticks. Raising level to 50 mid-count clears the spin timer; no timeout occurs.
- Detergent flag: pulse detergent_sensed with door_lock=0 → no set. Pulse with door_lock=1 → detergent_added=1 within 3 cycles. Drop door_lock → flag clears one cycle later.
